// File: rtl/lpf_filter.sv
// rtl/lpf_filter.sv - first-order IIR low-pass step with a shift-add multiplier
//
// Purpose:
//   Computes y = y_ex + floor(k * (x - y_ex)) once per start strobe, where
//   k = lpf_k / 2^K_FRAC is clamped to at most 1.0. The product is formed by
//   a radix-2 shift-add multiplier over K_FRAC+1 cycles, so no DSP is needed.
//   The caller feeds the previous output back on y_ex.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous reset, active-high
//   lpfsta    in   1   start strobe, sampled only when idle
//   y_ex      in   32  previous filter output, signed
//   x         in   32  new input sample, signed
//   lpf_k     in   32  unsigned coefficient, K_FRAC fractional bits
//   y         out  32  filtered result, held between runs
//   lpf_done  out  1   one-cycle pulse, y valid in the same cycle
//   lpf_busy  out  1   high from start accept until lpf_done

`timescale 1ns/1ps

module lpf_filter #(
    parameter int K_FRAC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lpfsta,
    input  logic [31:0] y_ex,
    input  logic [31:0] x,
    input  logic [31:0] lpf_k,
    output logic [31:0] y,
    output logic        lpf_done,
    output logic        lpf_busy
);

    // 33-bit difference times a (K_FRAC+1)-bit coefficient, with sign headroom.
    localparam int P_W   = 33 + K_FRAC + 2;
    localparam int CNT_W = $clog2(K_FRAC + 2);
    localparam logic [31:0] K_ONE = 32'(1) << K_FRAC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MUL  = 2'd2,
        S_ACC  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]        r_x;
    logic [31:0]        r_yex;
    logic [K_FRAC:0]    r_kc;
    logic [32:0]        r_d;
    logic [P_W-1:0]     r_p;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_y;
    logic               r_done;
    logic               r_busy;

    logic [K_FRAC:0]    w_kc;
    logic [32:0]        w_d;
    logic [P_W-1:0]     w_d_ext;
    logic [P_W-1:0]     w_addend;
    logic [P_W-1:0]     w_q;
    logic [33:0]        w_sum;
    logic               w_unused;

    // Coefficients above 1.0 saturate to exactly 1.0.
    assign w_kc = (lpf_k > K_ONE) ? K_ONE[K_FRAC:0] : lpf_k[K_FRAC:0];

    // Sign-extend both operands by one bit so the difference never overflows.
    assign w_d = {r_x[31], r_x} - {r_yex[31], r_yex};

    assign w_d_ext  = {{(P_W-33){r_d[32]}}, r_d};
    assign w_addend = w_d_ext << r_cnt;

    // Arithmetic shift floors toward minus infinity.
    assign w_q   = $unsigned($signed(r_p) >>> K_FRAC);
    assign w_sum = {{2{r_yex[31]}}, r_yex} + w_q[33:0];

    // The result always lies between y_ex and x, so the top sum bits and the
    // upper quotient bits carry only sign copies.
    assign w_unused = ^{w_sum[33:32], w_q[P_W-1:34]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (lpfsta) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_next = S_MUL;
            end
            S_MUL: begin
                if (r_cnt == CNT_W'(K_FRAC)) begin
                    w_state_next = S_ACC;
                end
            end
            S_ACC: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_yex  <= '0;
            r_kc   <= '0;
            r_d    <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lpfsta) begin
                        r_x    <= x;
                        r_yex  <= y_ex;
                        r_kc   <= w_kc;
                        r_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_d   <= w_d;
                    r_p   <= '0;
                    r_cnt <= '0;
                end
                S_MUL: begin
                    // LSB-first: bit r_cnt of kc contributes d << r_cnt.
                    if (r_kc[r_cnt]) begin
                        r_p <= r_p + w_addend;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_ACC: begin
                    r_y    <= w_sum[31:0];
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign y        = r_y;
    assign lpf_done = r_done;
    assign lpf_busy = r_busy;

endmodule

// File: tb/tb_lpf_filter.sv
// tb/tb_lpf_filter.sv - self-checking bench for lpf_filter

`timescale 1ns/1ps

module tb_lpf_filter;

    localparam int KF      = 16;
    localparam int LATENCY = KF + 3;
    localparam int TMO     = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lpfsta = 1'b0;
    logic [31:0] y_ex = '0;
    logic [31:0] x = '0;
    logic [31:0] lpf_k = '0;
    logic [31:0] y;
    logic        lpf_done;
    logic        lpf_busy;

    int n_checks = 0;
    int n_fail   = 0;

    lpf_filter #(.K_FRAC(KF)) dut (
        .clk      (clk),
        .rst      (rst),
        .lpfsta   (lpfsta),
        .y_ex     (y_ex),
        .x        (x),
        .lpf_k    (lpf_k),
        .y        (y),
        .lpf_done (lpf_done),
        .lpf_busy (lpf_busy)
    );

    always #5 clk = ~clk;

    // Reference: exact integer arithmetic on the filter equation.
    function automatic logic [31:0] ref_y(input logic [31:0] ye, input logic [31:0] xx,
                                          input logic [31:0] k);
        longint d, kc, p, q, s;
        d  = longint'($signed(xx)) - longint'($signed(ye));
        kc = (k > 32'h0001_0000) ? 64'sd65536 : longint'(k);
        p  = d * kc;
        q  = p >>> KF;
        s  = longint'($signed(ye)) + q;
        return s[31:0];
    endfunction

    // Apply operands with a one-cycle strobe; returns after edge E0, then
    // scrambles the inputs so late changes would be visible if they leaked in.
    task automatic start_op(input logic [31:0] ye, input logic [31:0] xx, input logic [31:0] k);
        @(negedge clk);
        y_ex   = ye;
        x      = xx;
        lpf_k  = k;
        lpfsta = 1'b1;
        @(posedge clk);
        #1;
        lpfsta = 1'b0;
        y_ex   = $urandom;
        x      = $urandom;
        lpf_k  = $urandom;
    endtask

    // Counts edges after E0 until lpf_done is seen; -1 on timeout.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cycles++;
            if (lpf_done) break;
            if (cycles >= TMO) begin
                cycles = -1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (y !== 32'h0 || lpf_done !== 1'b0 || lpf_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: y=%h done=%b busy=%b, required y=0 done=0 busy=0",
                     y, lpf_done, lpf_busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [31:0] t_ye [8] = '{32'h46, 32'h46, 32'h46, 32'h46,
                                  32'd100, 32'h0, 32'h7FFFFFFF, 32'h7FFFFFFF};
        logic [31:0] t_x  [8] = '{32'h56, 32'h56, 32'h56, 32'h56,
                                  32'hFFFFFF9C, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] t_k  [8] = '{32'h66, 32'h8000, 32'h10000, 32'hFFFFFFFF,
                                  32'h4000, 32'h8000, 32'h10000, 32'h0};
        logic [31:0] t_y  [8] = '{32'h46, 32'h4E, 32'h56, 32'h56,
                                  32'd50, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        int cyc;
        for (int i = 0; i < 8; i++) begin
            start_op(t_ye[i], t_x[i], t_k[i]);
            n_checks++;
            if (lpf_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_busy: busy=%b after accept, required 1", i, lpf_busy);
            end
            wait_done(cyc);
            n_checks++;
            if (cyc !== LATENCY) begin
                n_fail++;
                $display("FAIL vec%0d_latency: %0d cycles, required %0d", i, cyc, LATENCY);
            end
            n_checks++;
            if (y !== t_y[i]) begin
                n_fail++;
                $display("FAIL vec%0d_y: y=%h, required %h", i, y, t_y[i]);
            end
            n_checks++;
            if (lpf_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_busy_clear: busy=%b with done, required 0", i, lpf_busy);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (lpf_done !== 1'b0 || y !== t_y[i]) begin
                n_fail++;
                $display("FAIL vec%0d_pulse_hold: done=%b y=%h, required done=0 y=%h",
                         i, lpf_done, y, t_y[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ye, xx, k, exp;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            ye = $urandom;
            xx = (i % 4 == 0) ? ye + ($urandom & 32'hFF) : $urandom;
            case (i % 5)
                0:       k = $urandom;
                1:       k = 32'h10000;
                default: k = $urandom_range(0, 32'h10000);
            endcase
            exp = ref_y(ye, xx, k);
            start_op(ye, xx, k);
            wait_done(cyc);
            n_checks++;
            if (cyc !== LATENCY || y !== exp) begin
                n_fail++;
                $display("FAIL rand%0d: y=%h after %0d cycles, required y=%h after %0d (ye=%h x=%h k=%h)",
                         i, y, cyc, exp, LATENCY, ye, xx, k);
            end
        end
    endtask

    task automatic test_ignore_restart();
        logic [31:0] exp;
        int done_at, extra;
        exp = ref_y(32'h0000_1000, 32'hFFFF_F000, 32'h0000_C000);
        start_op(32'h0000_1000, 32'hFFFF_F000, 32'h0000_C000);
        done_at = -1;
        // Strobe again mid-run (edge 6) and in the ACC cycle (edge 19).
        for (int n = 1; n <= TMO; n++) begin
            @(negedge clk);
            lpfsta = (n == 6 || n == LATENCY);
            y_ex   = 32'h1234_5678;
            x      = 32'h0765_4321;
            lpf_k  = 32'h0000_4000;
            @(posedge clk);
            #1;
            lpfsta = 1'b0;
            if (lpf_done) begin
                done_at = n;
                break;
            end
        end
        n_checks++;
        if (done_at !== LATENCY || y !== exp) begin
            n_fail++;
            $display("FAIL ignore_busy: done at %0d y=%h, required at %0d y=%h",
                     done_at, y, LATENCY, exp);
        end
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (lpf_done || lpf_busy) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL ignore_no_queue: %0d cycles of done/busy after run, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2;
        int cyc;
        exp1 = ref_y(32'hFFFF_0000, 32'h0001_0000, 32'h0000_2000);
        exp2 = ref_y(32'h0000_0005, 32'h8000_0000, 32'h0000_FFFF);
        start_op(32'hFFFF_0000, 32'h0001_0000, 32'h0000_2000);
        wait_done(cyc);
        n_checks++;
        if (cyc !== LATENCY || y !== exp1) begin
            n_fail++;
            $display("FAIL b2b_first: y=%h after %0d, required y=%h after %0d",
                     y, cyc, exp1, LATENCY);
        end
        // Strobe sampled on the edge right after the lpf_done cycle.
        start_op(32'h0000_0005, 32'h8000_0000, 32'h0000_FFFF);
        n_checks++;
        if (lpf_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b, required 1", lpf_busy);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc !== LATENCY || y !== exp2) begin
            n_fail++;
            $display("FAIL b2b_second: y=%h after %0d, required y=%h after %0d",
                     y, cyc, exp2, LATENCY);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] exp;
        int seen, cyc;
        start_op(32'h0000_0010, 32'h0000_0F00, 32'h0000_8000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (y !== 32'h0 || lpf_busy !== 1'b0 || lpf_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: y=%h busy=%b done=%b, required 0 0 0",
                     y, lpf_busy, lpf_done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (lpf_done || lpf_busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midrun_abort: %0d cycles of done/busy after reset, required 0", seen);
        end
        exp = ref_y(32'hFFFF_FF00, 32'h0000_0100, 32'h0000_A000);
        start_op(32'hFFFF_FF00, 32'h0000_0100, 32'h0000_A000);
        wait_done(cyc);
        n_checks++;
        if (cyc !== LATENCY || y !== exp) begin
            n_fail++;
            $display("FAIL midrun_fresh: y=%h after %0d, required y=%h after %0d",
                     y, cyc, exp, LATENCY);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_ignore_restart();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
